// File: rtl/lbm_pkg.sv
// Shared types and constants for the LBM lattice renderer.
// Populations, render modes, pipeline sideband and normalisation shift.
package lbm_pkg;

  localparam int unsigned NUM_DIR = 9;
  localparam int unsigned POP_W   = 8;
  localparam int unsigned DENS_W  = 12;
  localparam int unsigned MOM_W   = 11;

  localparam int unsigned DIR_C  = 0;
  localparam int unsigned DIR_N  = 1;
  localparam int unsigned DIR_NE = 2;
  localparam int unsigned DIR_E  = 3;
  localparam int unsigned DIR_SE = 4;
  localparam int unsigned DIR_S  = 5;
  localparam int unsigned DIR_SW = 6;
  localparam int unsigned DIR_W  = 7;
  localparam int unsigned DIR_NW = 8;

  typedef enum logic [1:0] {
    MODE_GREY = 2'd0,
    MODE_HEAT = 2'd1,
    MODE_F0   = 2'd2,
    MODE_MOMX = 2'd3
  } mode_t;

  typedef logic [NUM_DIR-1:0][POP_W-1:0] pops_t;

  // Sideband travelling with each pixel through the pipeline
  typedef struct packed {
    logic  in_lat;
    mode_t mode;
    logic  hsync;
    logic  vsync;
    logic  active_draw;
  } pix_ctl_t;

  // Right shift that brings the previous frame's peak density into 8 bits
  function automatic logic [2:0] norm_shift(input logic [DENS_W-1:0] max_v);
    logic [3:0] msb;
    msb = '0;
    for (int i = 0; i < int'(DENS_W); i++) begin
      if (max_v[i]) msb = 4'(i);
    end
    return (msb > 4'd7) ? 3'(msb - 4'd7) : 3'd0;
  endfunction

endpackage

// File: rtl/lbm_density_render_if.sv
// Read-only port onto the lattice BRAM (two-cycle read latency).
interface lbm_density_render_if #(
  parameter int unsigned ADDR_W = 15
) ();
  logic [ADDR_W-1:0] addr;
  lbm_pkg::pops_t    data;

  modport master (output addr, input data);
  modport slave  (input addr, output data);
endinterface

// File: rtl/lbm_colormap.sv
// Normalisation (stage 5) and colour mapping (stage 6) of per-cell lattice values.
// Both stages are registered; the stage-6 register drives the video outputs.
module lbm_colormap
  import lbm_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  pix_ctl_t                 ctl_in,
  input  logic [DENS_W-1:0]        dens_in,
  input  logic signed [MOM_W-1:0]  momx_in,
  input  logic [POP_W-1:0]         f0_in,
  input  logic [DENS_W-1:0]        max_prev_in,
  output logic [7:0]               red_out,
  output logic [7:0]               green_out,
  output logic [7:0]               blue_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     active_draw_out
);

  logic [2:0]        shift_c;
  logic [DENS_W-1:0] shifted_c;
  logic [MOM_W-1:0]  mom_abs_c;
  logic [7:0]        pix_c, mag_c;

  always_comb begin
    shift_c   = norm_shift(max_prev_in);
    shifted_c = dens_in >> shift_c;
    pix_c     = (|shifted_c[DENS_W-1:8]) ? 8'hff : shifted_c[7:0];
    mom_abs_c = momx_in[MOM_W-1] ? MOM_W'(-momx_in) : MOM_W'(momx_in);
    mag_c     = (|mom_abs_c[MOM_W-1:8]) ? 8'hff : mom_abs_c[7:0];
  end

  pix_ctl_t   ctl5;
  logic [7:0] pix5, mag5, f05;
  logic       mpos5, mneg5;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ctl5  <= '0;
      pix5  <= '0;
      mag5  <= '0;
      f05   <= '0;
      mpos5 <= 1'b0;
      mneg5 <= 1'b0;
    end else begin
      ctl5  <= ctl_in;
      pix5  <= pix_c;
      mag5  <= mag_c;
      f05   <= f0_in;
      mpos5 <= !momx_in[MOM_W-1] && (momx_in != '0);
      mneg5 <= momx_in[MOM_W-1];
    end
  end

  logic [7:0] r_c, g_c, b_c;

  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (ctl5.in_lat) begin
      unique case (ctl5.mode)
        MODE_GREY: begin r_c = pix5; g_c = pix5; b_c = pix5; end
        MODE_HEAT: begin r_c = pix5; b_c = 8'hff - pix5; end
        MODE_F0:   begin r_c = f05; g_c = f05; b_c = f05; end
        MODE_MOMX: begin
          if (mpos5) r_c = mag5;
          if (mneg5) b_c = mag5;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      red_out         <= '0;
      green_out       <= '0;
      blue_out        <= '0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
      active_draw_out <= 1'b0;
    end else begin
      red_out         <= r_c;
      green_out       <= g_c;
      blue_out        <= b_c;
      hsync_out       <= ctl5.hsync;
      vsync_out       <= ctl5.vsync;
      active_draw_out <= ctl5.active_draw;
    end
  end

endmodule

// File: rtl/lbm_density_render.sv
// Video-side lattice renderer: screen coordinates -> BRAM address -> RGB pixel.
// Six-stage pipeline; normalisation uses the previous frame's peak density.
module lbm_density_render
  import lbm_pkg::*;
#(
  parameter  int unsigned HPIXELS    = 160,
  parameter  int unsigned VPIXELS    = 120,
  parameter  int unsigned SCALE_LOG2 = 2,
  localparam int unsigned BRAM_SIZE  = $clog2(HPIXELS * VPIXELS)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [10:0]               hcount_in,
  input  logic [9:0]                vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      active_draw_in,
  input  logic                      new_frame_in,
  input  logic [1:0]                mode_in,
  lbm_density_render_if.master      bram,
  output logic [7:0]                red_out,
  output logic [7:0]                green_out,
  output logic [7:0]                blue_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      active_draw_out
);

  logic [10:0] cx_c;
  logic [9:0]  cy_c;
  logic        in_lat_c;

  always_comb begin
    cx_c     = hcount_in >> SCALE_LOG2;
    cy_c     = vcount_in >> SCALE_LOG2;
    in_lat_c = active_draw_in && (32'(cx_c) < HPIXELS) && (32'(cy_c) < VPIXELS);
  end

  logic [DENS_W-1:0]       dens_c;
  logic [9:0]              pos_c, neg_c;
  logic signed [MOM_W-1:0] momx_c;

  always_comb begin
    dens_c = '0;
    for (int i = 0; i < int'(NUM_DIR); i++) begin
      dens_c = dens_c + DENS_W'(bram.data[i]);
    end
    pos_c  = 10'(bram.data[DIR_E]) + 10'(bram.data[DIR_NE]) + 10'(bram.data[DIR_SE]);
    neg_c  = 10'(bram.data[DIR_W]) + 10'(bram.data[DIR_NW]) + 10'(bram.data[DIR_SW]);
    momx_c = $signed(MOM_W'(pos_c)) - $signed(MOM_W'(neg_c));
  end

  pix_ctl_t                s1, s2, s3, s4;
  logic [DENS_W-1:0]       dens4;
  logic signed [MOM_W-1:0] momx4;
  logic [POP_W-1:0]        f04;

  // Stage 1 address, sideband carried across the BRAM latency, stage 4 reduction
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bram.addr <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      s4        <= '0;
      dens4     <= '0;
      momx4     <= '0;
      f04       <= '0;
    end else begin
      if (in_lat_c) bram.addr <= BRAM_SIZE'(32'(cy_c) * HPIXELS + 32'(cx_c));
      s1    <= '{in_lat: in_lat_c, mode: mode_t'(mode_in), hsync: hsync_in,
                 vsync: vsync_in, active_draw: active_draw_in};
      s2    <= s1;
      s3    <= s2;
      s4    <= s3;
      dens4 <= dens_c;
      momx4 <= momx_c;
      f04   <= bram.data[DIR_C];
    end
  end

  logic [DENS_W-1:0] run_max, max_prev;

  // A stage-4 sample coinciding with the frame pulse belongs to the new frame
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      run_max  <= '0;
      max_prev <= '0;
    end else if (new_frame_in) begin
      max_prev <= run_max;
      run_max  <= s4.in_lat ? dens4 : '0;
    end else if (s4.in_lat && (dens4 > run_max)) begin
      run_max  <= dens4;
    end
  end

  lbm_colormap u_colormap (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .ctl_in          (s4),
    .dens_in         (dens4),
    .momx_in         (momx4),
    .f0_in           (f04),
    .max_prev_in     (max_prev),
    .red_out         (red_out),
    .green_out       (green_out),
    .blue_out        (blue_out),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .active_draw_out (active_draw_out)
  );

endmodule

// File: tb/tb_lbm_density_render.sv
// Bench for lbm_density_render: frame-level reference model plus literal pixel checks.
module tb_lbm_density_render;
  import lbm_pkg::*;

  localparam int unsigned HP = 160;
  localparam int unsigned VP = 120;
  localparam int unsigned SL = 2;
  localparam int unsigned AW = $clog2(HP * VP);
  localparam int NC   = HP * VP;
  localparam int NIDX = 4096;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, active_draw_in, new_frame_in;
  logic [1:0]  mode_in;
  logic [7:0]  red_out, green_out, blue_out;
  logic        hsync_out, vsync_out, active_draw_out;

  always #5 clk_in = ~clk_in;

  lbm_density_render_if #(.ADDR_W(AW)) bif ();

  lbm_density_render #(.HPIXELS(HP), .VPIXELS(VP), .SCALE_LOG2(SL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active_draw_in(active_draw_in),
    .new_frame_in(new_frame_in), .mode_in(mode_in), .bram(bif),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .active_draw_out(active_draw_out)
  );

  // Lattice BRAM with two-cycle read latency
  pops_t mem [NC];
  pops_t rd1, rd2;
  always_ff @(posedge clk_in) begin
    rd1 <= mem[bif.addr];
    rd2 <= rd1;
  end
  assign bif.data = rd2;

  bit    rec_inlat [NIDX];
  bit    rec_hs [NIDX], rec_vs [NIDX], rec_ad [NIDX], rec_nf [NIDX];
  int    rec_addr [NIDX], rec_mode [NIDX];
  int    er [NIDX], eg [NIDX], eb [NIDX];
  bit    lit_set [NIDX];
  int    lr [NIDX], lg [NIDX], lb [NIDX];
  string lname [NIDX];

  int cur = -1;
  int base = 0;
  int max_prev_m = 0, run_max_m = 0;
  bit release_pending = 0;
  int n_tests = 0, n_fail = 0;

  function automatic int dens_of(int a);
    int s = 0;
    for (int i = 0; i < 9; i++) s += int'(mem[a][i]);
    return s;
  endfunction

  function automatic int momx_of(int a);
    return int'(mem[a][DIR_E]) + int'(mem[a][DIR_NE]) + int'(mem[a][DIR_SE])
         - int'(mem[a][DIR_W]) - int'(mem[a][DIR_NW]) - int'(mem[a][DIR_SW]);
  endfunction

  // Expected colour of pixel p given the maximum of the last completed frame
  function automatic void render(int p);
    int d, m, msb, sh, pix, mag;
    er[p] = 0; eg[p] = 0; eb[p] = 0;
    if (!rec_inlat[p]) return;
    d = dens_of(rec_addr[p]);
    m = momx_of(rec_addr[p]);
    msb = -1;
    for (int b = 0; b < 12; b++) if (((max_prev_m >> b) & 1) == 1) msb = b;
    sh  = (msb > 7) ? msb - 7 : 0;
    pix = d >> sh;   if (pix > 255) pix = 255;
    mag = (m < 0) ? -m : m; if (mag > 255) mag = 255;
    case (rec_mode[p])
      0: begin er[p] = pix; eg[p] = pix; eb[p] = pix; end
      1: begin er[p] = pix; eb[p] = 255 - pix; end
      2: begin er[p] = int'(mem[rec_addr[p]][DIR_C]); eg[p] = er[p]; eb[p] = er[p]; end
      default: begin if (m > 0) er[p] = mag; if (m < 0) eb[p] = mag; end
    endcase
  endfunction

  // Pixel p reaches the density stage in the same cycle as the frame flag of index p+4
  function automatic void model_step(int n);
    int  p = n - 4;
    bit  pv = 0;
    int  d = 0;
    if (p >= base) begin
      render(p);
      pv = rec_inlat[p];
      if (pv) d = dens_of(rec_addr[p]);
    end
    if (rec_nf[n]) begin
      max_prev_m = run_max_m;
      run_max_m  = pv ? d : 0;
    end else if (pv && d > run_max_m) begin
      run_max_m = d;
    end
  endfunction

  task automatic drv(input int hc, input int vc, input bit ad, input bit nf, input int md);
    int cx, cy;
    @(posedge clk_in);
    #1;
    cur++;
    if (release_pending) begin
      rst_in = 1'b1;
      base = cur;
      release_pending = 0;
      max_prev_m = 0;
      run_max_m = 0;
    end
    hcount_in      = 11'(hc);
    vcount_in      = 10'(vc);
    hsync_in       = cur[1];
    vsync_in       = cur[3];
    active_draw_in = ad;
    new_frame_in   = nf;
    mode_in        = 2'(md);
    cx = hc >> SL;
    cy = vc >> SL;
    rec_inlat[cur] = ad && (cx < int'(HP)) && (cy < int'(VP));
    rec_addr[cur]  = rec_inlat[cur] ? cy * int'(HP) + cx : 0;
    rec_mode[cur]  = md;
    rec_hs[cur] = cur[1]; rec_vs[cur] = cur[3]; rec_ad[cur] = ad; rec_nf[cur] = nf;
    model_step(cur);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drv(0, 0, 0, 0, 0);
  endtask

  task automatic px(input int cx, input int md, input int r, input int g, input int b,
                    input string nm);
    drv(cx * 4 + 3, 2, 1, 0, md);
    lit_set[cur] = 1; lr[cur] = r; lg[cur] = g; lb[cur] = b; lname[cur] = nm;
  endtask

  task automatic lit_px(input int hc, input int vc, input bit ad, input int md, input string nm);
    drv(hc, vc, ad, 0, md);
    lit_set[cur] = 1; lr[cur] = 0; lg[cur] = 0; lb[cur] = 0; lname[cur] = nm;
  endtask

  function automatic void chk(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, int'(bif.addr), 0);
    chk({tag, "_red"}, int'(red_out), 0);
    chk({tag, "_green"}, int'(green_out), 0);
    chk({tag, "_blue"}, int'(blue_out), 0);
    chk({tag, "_hsync"}, int'(hsync_out), 0);
    chk({tag, "_vsync"}, int'(vsync_out), 0);
    chk({tag, "_active"}, int'(active_draw_out), 0);
  endtask

  // Every cycle: the pixel driven six cycles earlier must be on the outputs
  int ci, xr, xg, xb;
  bit xh, xv, xa;
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && cur >= 0) begin
      ci = cur - 6;
      if (ci < base) begin
        xr = 0; xg = 0; xb = 0; xh = 0; xv = 0; xa = 0;
      end else begin
        xr = er[ci]; xg = eg[ci]; xb = eb[ci];
        xh = rec_hs[ci]; xv = rec_vs[ci]; xa = rec_ad[ci];
      end
      n_tests++;
      if (int'(red_out) != xr || int'(green_out) != xg || int'(blue_out) != xb ||
          hsync_out !== xh || vsync_out !== xv || active_draw_out !== xa) begin
        n_fail++;
        $display("FAIL pixel idx=%0d: got rgb=%0d,%0d,%0d sync=%b%b%b, expected rgb=%0d,%0d,%0d sync=%b%b%b",
                 ci, red_out, green_out, blue_out, hsync_out, vsync_out, active_draw_out,
                 xr, xg, xb, xh, xv, xa);
      end
      if (ci >= base && lit_set[ci]) begin
        lit_set[ci] = 0;
        n_tests++;
        if (int'(red_out) != lr[ci] || int'(green_out) != lg[ci] || int'(blue_out) != lb[ci]) begin
          n_fail++;
          $display("FAIL %s: got rgb=%0d,%0d,%0d, expected rgb=%0d,%0d,%0d",
                   lname[ci], red_out, green_out, blue_out, lr[ci], lg[ci], lb[ci]);
        end
      end
    end
  end

  initial begin
    rst_in = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    active_draw_in = 0; new_frame_in = 0; mode_in = '0;
    for (int i = 0; i < NC; i++) mem[i] = '0;
    for (int i = 0; i < 9; i++) mem[1][i] = 8'd10;           // A: dens 90
    for (int i = 0; i < 9; i++) mem[2][i] = 8'd111;          // B: dens 1000
    mem[2][DIR_C] = 8'd112;
    for (int i = 0; i < 9; i++) mem[3][i] = 8'd255;          // C: dens 2295
    mem[4][DIR_E] = 8'd50; mem[4][DIR_NE] = 8'd50; mem[4][DIR_SE] = 8'd50;  // D: momx +150
    mem[5][DIR_W] = 8'd50; mem[5][DIR_NW] = 8'd50; mem[5][DIR_SW] = 8'd50;  // E: momx -150
    mem[6][DIR_E] = 8'd134; mem[6][DIR_NE] = 8'd133; mem[6][DIR_SE] = 8'd133; // F: momx +400
    for (int i = 0; i < 9; i++) mem[7][i] = 8'd3;            // G: f0 77
    mem[7][DIR_C] = 8'd77;
    mem[7][DIR_N] = 8'd3; mem[7][DIR_S] = 8'd3;

    #12;
    chk_all_zero("reset");
    release_pending = 1;

    // Address generation and hold
    drv(0, 0, 1, 0, 0);
    drv(4, 0, 1, 0, 0);
    @(negedge clk_in); chk("addr_0_0", int'(bif.addr), 0);
    drv(0, 4, 1, 0, 0);
    @(negedge clk_in); chk("addr_4_0", int'(bif.addr), 1);
    idle(1);
    @(negedge clk_in); chk("addr_0_4", int'(bif.addr), 160);
    idle(1);
    @(negedge clk_in); chk("addr_hold", int'(bif.addr), 160);

    // Frame 1: unscaled
    px(1, 0, 90, 90, 90, "grey_dens90");
    px(1, 1, 90, 0, 165, "heat_dens90");
    px(4, 3, 150, 0, 0, "momx_pos");
    px(5, 3, 0, 0, 150, "momx_neg");
    px(6, 3, 255, 0, 0, "momx_sat");
    px(7, 2, 77, 77, 77, "f0");
    px(2, 0, 255, 255, 255, "dens1000_shift0");
    for (int m = 0; m < 4; m++) begin
      lit_px(640, 2, 1, m, "beyond_h");
      lit_px(7, 2, 0, m, "inactive");
    end
    lit_px(7, 480, 1, 0, "beyond_v");
    idle(6);
    drv(0, 0, 0, 1, 0);
    idle(4);

    // Frame 2: previous peak 1000 -> shift 2
    px(2, 0, 250, 250, 250, "norm_1000");
    px(2, 1, 250, 0, 5, "heat_norm");
    px(1, 0, 22, 22, 22, "norm_90");
    px(3, 0, 255, 255, 255, "sat_2295");
    px(7, 2, 77, 77, 77, "f0_noshift");
    idle(6);
    drv(0, 0, 0, 1, 0);
    idle(4);

    // Frame 3: previous peak 2295 -> shift 4; last pixel coincides with the frame flag
    px(3, 0, 143, 143, 143, "norm_2295");
    px(2, 0, 62, 62, 62, "shift4_1000");
    idle(6);
    px(2, 0, 62, 62, 62, "seed_src");
    idle(3);
    drv(0, 0, 0, 1, 0);
    idle(6);
    drv(0, 0, 0, 1, 0);
    idle(4);

    // Frame 5: peak seeded from the coincident sample (1000) -> shift 2
    px(2, 0, 250, 250, 250, "seeded_peak");
    px(1, 0, 22, 22, 22, "seeded_90");
    for (int i = 0; i < 4; i++) px(3, i % 4, 0, 0, 0, "pre_reset");
    for (int i = 0; i < 4; i++) lit_set[cur - i] = 0;

    // Mid-line asynchronous reset
    #2;
    rst_in = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(posedge clk_in);
    release_pending = 1;
    px(2, 0, 255, 255, 255, "post_rst_unscaled");
    px(1, 0, 90, 90, 90, "post_rst_90");
    px(4, 3, 150, 0, 0, "post_rst_momx");
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
